// File: rtl/fe_mul_pkg.sv
// fe_mul_pkg: shared types and constants for the fe_mulx arbiters.
//   FE_W    : field element width in bits
//   state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   clog2   : index width for n requesters, never less than 1 bit
package fe_mul_pkg;
  localparam int FE_W = 320;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fe_mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority; priority falls off modulo N
//   grant : one-hot winner
//   valid : at least one request is present
module rr_pick
  import fe_mul_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);
  logic [PW-1:0] idx;
  // Scan from the farthest offset down to ptr so the nearest request wins last.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/fe_mul_arbiter.sv
// fe_mul_arbiter: round-robin owner of the shared fe_mulx field multiplier.
//   clk, resetn          : multiplier clock, async active-low reset
//   req, req_op_a/b      : per-requester level request and packed operands
//   done, err, res       : per-requester completion pulse, watchdog flag, product
//   mul_op_a/b, mul_valid: registered operands and start pulse to fe_mulx
//   mul_res, mul_done    : fe_mulx result and completion pulse
//   busy, grant_id       : not idle; current or last owner
//   stray_done           : sticky, mul_done seen outside WAIT
module fe_mul_arbiter
  import fe_mul_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = FE_W,
  parameter int TIMEOUT = 255,
  parameter int GW      = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_op_a,
  input  logic [NREQ*W-1:0] req_op_b,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [W-1:0]      res,
  output logic [W-1:0]      mul_op_a,
  output logic [W-1:0]      mul_op_b,
  output logic              mul_valid,
  input  logic [W-1:0]      mul_res,
  input  logic              mul_done,
  output logic              busy,
  output logic [GW-1:0]     grant_id,
  output logic              stray_done
);
  state_t state;
  logic [15:0] cnt;
  logic [GW-1:0] rr_ptr, pick_id;
  logic [NREQ-1:0] pick;
  logic pick_valid;
  logic [W-1:0] pick_a, pick_b;

  rr_pick #(.N(NREQ), .PW(GW)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .grant(pick),
    .valid(pick_valid)
  );

  always_comb begin
    pick_id = '0;
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) begin
        pick_id = GW'(i);
        pick_a = req_op_a[i*W +: W];
        pick_b = req_op_b[i*W +: W];
      end
  end

  // done/err/mul_valid are set on the transition into the state they belong to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      done <= '0;
      err <= 1'b0;
      res <= '0;
      mul_op_a <= '0;
      mul_op_b <= '0;
      mul_valid <= 1'b0;
      busy <= 1'b0;
      grant_id <= '0;
      rr_ptr <= '0;
      stray_done <= 1'b0;
      cnt <= '0;
    end else begin
      done <= '0;
      err <= 1'b0;
      mul_valid <= 1'b0;
      if (mul_done && state != WAIT) stray_done <= 1'b1;
      case (state)
        IDLE:
          if (pick_valid) begin
            mul_op_a <= pick_a;
            mul_op_b <= pick_b;
            grant_id <= pick_id;
            mul_valid <= 1'b1;
            busy <= 1'b1;
            state <= ISSUE;
          end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT:
          if (mul_done) begin
            res <= mul_res;
            done[grant_id] <= 1'b1;
            state <= DONE;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            err <= 1'b1;
            done[grant_id] <= 1'b1;
            state <= DONE;
          end else cnt <= cnt + 16'd1;
        DONE: begin
          rr_ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fe_mul_arbiter.sv
// tb_fe_mul_arbiter: scoreboard bench with a transaction-level arbiter and multiplier model.
module tb_fe_mul_arbiter;
  localparam int NREQ = 2;
  localparam int W = 32;
  localparam int TO = 16;
  localparam int GW = fe_mul_pkg::clog2(NREQ);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] op_a = '0, op_b = '0;
  logic [NREQ-1:0] done;
  logic err, mul_valid, busy, stray_done;
  logic [W-1:0] res, mul_op_a, mul_op_b;
  logic [W-1:0] mul_res = '0;
  logic mul_done = 1'b0;
  logic [GW-1:0] grant_id;

  fe_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_op_a(op_a), .req_op_b(op_b),
    .done(done), .err(err), .res(res), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_valid(mul_valid), .mul_res(mul_res), .mul_done(mul_done), .busy(busy),
    .grant_id(grant_id), .stray_done(stray_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    logic [W-1:0] res;
    bit err;
    int at;
  } exp_t;

  int errors = 0, checks = 0, cyc = 0;
  int lat_fixed = 0, rate = 0, ref_ptr = 0, mcnt = 0;
  bit force_hang = 0, rand_hang = 0, stray_req = 0, cur_hang = 0;
  logic [W-1:0] cur_prod;
  exp_t sbq[$];
  int grants[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier model plus monitor: predicts each grant from the request set and
  // rotating priority, then checks every done pulse against the queued expectation.
  initial begin
    int w, lat;
    logic [W-1:0] a, b;
    logic [63:0] p;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!resetn) begin
        sbq.delete();
        mcnt = 0;
        mul_done = 0;
        ref_ptr = 0;
      end else begin
        mul_done = 0;
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0 && !cur_hang) begin
            mul_done = 1;
            mul_res = cur_prod;
          end
        end
        if (stray_req) begin
          mul_done = 1;
          mul_res = $urandom;
          stray_req = 0;
        end
        if (mul_valid) begin
          w = -1;
          for (int k = 0; k < NREQ; k++)
            if (w < 0 && req[(ref_ptr + k) % NREQ]) w = (ref_ptr + k) % NREQ;
          if (w < 0) chk("grant_without_request", {63'd0, mul_valid}, 64'd0);
          else begin
            a = op_a[w*W +: W];
            b = op_b[w*W +: W];
            chk("grant_id", 64'(grant_id), 64'(w));
            chk("issue_op_a", 64'(mul_op_a), 64'(a));
            chk("issue_op_b", 64'(mul_op_b), 64'(b));
            p = 64'(a) * 64'(b);
            cur_prod = p[W-1:0];
            lat = lat_fixed > 0 ? lat_fixed : $urandom_range(1, TO - 2);
            cur_hang = force_hang || (rand_hang && $urandom_range(0, 7) == 0);
            mcnt = lat;
            sbq.push_back('{w, cur_prod, cur_hang, cur_hang ? cyc + TO + 1 : cyc + lat + 1});
            grants.push_back(w);
            ref_ptr = (w + 1) % NREQ;
          end
        end
        if (done != '0) begin
          if (sbq.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
          else begin
            e = sbq.pop_front();
            chk("done_vec", 64'(done), 64'(1) << e.idx);
            chk("done_err", {63'd0, err}, {63'd0, e.err});
            if (!e.err) chk("done_res", 64'(res), 64'(e.res));
            chk("done_cycle", 64'(cyc), 64'(e.at));
          end
        end
      end
    end
  end

  // Requesters: drop on their own done, raise randomly at the given rate.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (req[i] && done[i]) req[i] = 1'b0;
      else if (!req[i] && rate > 0 && $urandom_range(1, 100) <= rate) begin
        op_a[i*W +: W] = $urandom;
        op_b[i*W +: W] = $urandom;
        req[i] = 1'b1;
      end
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      step();
      ok = mul_valid;
    end
    if (!ok) chk({name, "_valid_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      step();
      ok = done != '0;
    end
    if (!ok) chk({name, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      step();
      ok = req == '0 && !busy && sbq.size() == 0;
    end
    if (!ok) chk({name, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    req = '0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, dn;
    logic [W-1:0] va;
    step();
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_mul_op_a", 64'(mul_op_a), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_stray", {63'd0, stray_done}, 64'd0);
    resetn = 1'b1;
    step();

    lat_fixed = 10;
    step();
    op_a[0 +: W] = 32'd5;
    op_b[0 +: W] = 32'd7;
    req[0] = 1'b1;
    t0 = cyc;
    wait_valid("single");
    chk("single_valid_cycle", 64'(cyc), 64'(t0 + 1));
    wait_done("single");
    chk("single_done_cycle", 64'(cyc), 64'(t0 + 12));
    chk("single_done_vec", 64'(done), 64'd1);
    chk("single_res", 64'(res), 64'd35);
    chk("single_err", {63'd0, err}, 64'd0);
    repeat (3) step();
    chk("res_held", 64'(res), 64'd35);
    chk("single_idle", {63'd0, busy}, 64'd0);

    do_reset();
    lat_fixed = 0;
    grants.delete();
    rate = 100;
    dn = 0;
    for (int n = 0; n < 400 && dn < 6; n++) begin
      step();
      if (done != '0) dn++;
    end
    rate = 0;
    wait_idle("contention");
    chk("contention_count", 64'(grants.size() >= 6), 64'd1);
    for (int k = 0; k < 6 && k < grants.size(); k++)
      chk("contention_order", 64'(grants[k]), 64'(k % 2));

    step();
    op_a[W +: W] = $urandom;
    op_b[W +: W] = $urandom;
    req[1] = 1'b1;
    wait_done("b2b_first");
    t0 = cyc;
    step();
    va = $urandom;
    op_a[W +: W] = va;
    op_b[W +: W] = $urandom;
    req[1] = 1'b1;
    wait_valid("b2b");
    chk("b2b_gap", 64'(cyc - t0), 64'd2);
    chk("b2b_new_op", 64'(mul_op_a), 64'(va));
    wait_done("b2b_second");
    wait_idle("b2b");

    lat_fixed = 8;
    step();
    va = 32'h1234_5678;
    op_a[0 +: W] = va;
    op_b[0 +: W] = 32'd3;
    req[0] = 1'b1;
    wait_valid("iso");
    op_a[0 +: W] = ~va;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("iso_op_a", 64'(mul_op_a), 64'(va));
    end
    wait_done("iso");
    wait_idle("iso");

    force_hang = 1;
    step();
    op_a[W +: W] = $urandom;
    req[1] = 1'b1;
    wait_valid("timeout");
    t0 = cyc;
    force_hang = 0;
    wait_done("timeout");
    chk("timeout_cycle", 64'(cyc), 64'(t0 + TO + 1));
    chk("timeout_err", {63'd0, err}, 64'd1);
    chk("timeout_vec", 64'(done), 64'd2);
    step();
    chk("timeout_err_clears", {63'd0, err}, 64'd0);
    chk("timeout_idle", {63'd0, busy}, 64'd0);
    chk("timeout_no_stray_yet", {63'd0, stray_done}, 64'd0);
    stray_req = 1;
    repeat (2) step();
    chk("late_done_stray", {63'd0, stray_done}, 64'd1);

    lat_fixed = 10;
    step();
    req[0] = 1'b1;
    wait_valid("rst_wait");
    repeat (3) step();
    resetn = 1'b0;
    req = '0;
    #1;
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_mul_op_a", 64'(mul_op_a), 64'd0);
    chk("async_res", 64'(res), 64'd0);
    chk("async_stray", {63'd0, stray_done}, 64'd0);
    chk("async_grant_id", 64'(grant_id), 64'd0);
    step();
    resetn = 1'b1;
    stray_req = 1;
    repeat (4) step();
    chk("post_reset_stray", {63'd0, stray_done}, 64'd1);
    chk("post_reset_no_done", 64'(done), 64'd0);

    lat_fixed = 0;
    rand_hang = 1;
    rate = 30;
    repeat (3000) step();
    rate = 0;
    wait_idle("random");
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
